// File: rtl/fin_test_gen.sv
// fin_test_gen: multi-channel test-frequency generator for freqMeter self-test.
// A free-running divider counter feeds per-channel tap selectors producing square
// waves (TAP), AND-combined patterns (AND) or counted bursts (BURST). Config is
// written to per-channel shadow registers and applied to all channels at once on
// commit, which also restarts the counter so every channel starts phase-coherent.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-low reset
//   en_i          count enable; 0 freezes counter and all channel state
//   cfg_we_i      write cfg_* into shadow register of channel cfg_ch_i
//   cfg_ch_i      channel select (>= CHANNELS: write ignored)
//   cfg_mode_i    00 OFF, 01 TAP, 10 AND, 11 BURST
//   cfg_tap_a_i   counter bit index A
//   cfg_tap_b_i   counter bit index B
//   cfg_inv_i     output inversion
//   cfg_burst_i   pulse count for BURST mode
//   cfg_commit_i  shadow -> active for all channels, restart
//   fin_o         generated signals (registered)
//   busy_o        BURST in progress
//   done_o        BURST complete, sticky until next commit
module fin_test_gen #(
    parameter int unsigned CHANNELS = 24,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TAP_W    = 5,
    parameter int unsigned CH_W     = 5,
    parameter int unsigned BURST_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [TAP_W-1:0]    cfg_tap_a_i,
    input  logic [TAP_W-1:0]    cfg_tap_b_i,
    input  logic                cfg_inv_i,
    input  logic [BURST_W-1:0]  cfg_burst_i,
    input  logic                cfg_commit_i,
    output logic [CHANNELS-1:0] fin_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] done_o
);

    localparam int unsigned IdxW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [1:0] {ModeOff, ModeTap, ModeAnd, ModeBurst} mode_e;

    typedef struct packed {
        logic [1:0]         mode;
        logic [TAP_W-1:0]   tap_a;
        logic [TAP_W-1:0]   tap_b;
        logic               inv;
        logic [BURST_W-1:0] burst;
    } cfg_t;

    // Out-of-range tap indices select the counter MSB.
    function automatic logic [IdxW-1:0] clamp_tap(input logic [TAP_W-1:0] t);
        if (int'(t) >= int'(CNT_W)) begin
            return IdxW'(CNT_W - 1);
        end
        return IdxW'(t);
    endfunction

    cfg_t               wr_cfg;
    cfg_t               shadow_q   [CHANNELS];
    cfg_t               active_q   [CHANNELS];
    cfg_t               commit_cfg [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;

    logic [CNT_W-1:0]   cnt_q;
    logic [BURST_W-1:0] rem_q [CHANNELS];
    logic [BURST_W-1:0] rem_d [CHANNELS];
    logic [CHANNELS-1:0] adm_q, adm_d;
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] busy_q, busy_d;
    logic [CHANNELS-1:0] fin_q, fin_d;

    // Per-channel combinational scratch.
    logic [CHANNELS-1:0] bit_a, bit_b, rise, fall, admit, is_burst, raw;

    always_comb begin
        wr_cfg = '{mode: cfg_mode_i, tap_a: cfg_tap_a_i, tap_b: cfg_tap_b_i,
                   inv: cfg_inv_i, burst: cfg_burst_i};
        for (int k = 0; k < CHANNELS; k++) begin
            wr_hit[k] = cfg_we_i && (cfg_ch_i == CH_W'(k));
            // A write in the commit cycle goes straight through to active.
            commit_cfg[k] = wr_hit[k] ? wr_cfg : shadow_q[k];
        end
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            bit_a[k]    = cnt_q[clamp_tap(active_q[k].tap_a)];
            bit_b[k]    = cnt_q[clamp_tap(active_q[k].tap_b)];
            is_burst[k] = active_q[k].mode == ModeBurst;
            rise[k]     = bit_a[k] & ~prev_q[k];
            fall[k]     = ~bit_a[k] & prev_q[k];
            admit[k]    = is_burst[k] & rise[k] & (rem_q[k] != '0);
            prev_d[k]   = bit_a[k];
            rem_d[k]    = admit[k] ? rem_q[k] - 1'b1 : rem_q[k];
            if (admit[k]) begin
                adm_d[k] = 1'b1;
            end else if (fall[k]) begin
                adm_d[k] = 1'b0;
            end else begin
                adm_d[k] = adm_q[k];
            end
            // Done once nothing is admitted and no pulses remain: this is the
            // fall of the last pulse, or the first cycle for a zero count.
            done_d[k] = done_q[k] | (is_burst[k] & ~adm_d[k] & (rem_d[k] == '0));
            busy_d[k] = is_burst[k] & ~done_d[k];
            unique case (mode_e'(active_q[k].mode))
                ModeOff:   raw[k] = 1'b0;
                ModeTap:   raw[k] = bit_a[k];
                ModeAnd:   raw[k] = bit_a[k] & bit_b[k];
                ModeBurst: raw[k] = bit_a[k] & (adm_q[k] | admit[k]);
                default:   raw[k] = 1'b0;
            endcase
            fin_d[k] = raw[k] ^ active_q[k].inv;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_hit[k]) begin
                    shadow_q[k] <= wr_cfg;
                end
                if (cfg_commit_i) begin
                    active_q[k] <= commit_cfg[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            adm_q  <= '0;
            prev_q <= '0;
            done_q <= '0;
            busy_q <= '0;
            fin_q  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                rem_q[k] <= '0;
            end
        end else if (cfg_commit_i) begin
            cnt_q  <= '0;
            adm_q  <= '0;
            prev_q <= '0;
            done_q <= '0;
            busy_q <= '0;
            if (en_i) begin
                fin_q <= fin_d;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                rem_q[k] <= commit_cfg[k].burst;
            end
        end else if (en_i) begin
            cnt_q  <= cnt_q + 1'b1;
            adm_q  <= adm_d;
            prev_q <= prev_d;
            done_q <= done_d;
            busy_q <= busy_d;
            fin_q  <= fin_d;
            for (int k = 0; k < CHANNELS; k++) begin
                rem_q[k] <= rem_d[k];
            end
        end
    end

    assign fin_o  = fin_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_fin_test_gen.sv
// Directed self-checking bench for fin_test_gen.
module tb_fin_test_gen;

    localparam int unsigned CHANNELS = 24;
    localparam int unsigned TAP_W    = 6;  // wide enough to express tap 40
    localparam logic [1:0] M_OFF = 2'b00, M_TAP = 2'b01, M_AND = 2'b10, M_BURST = 2'b11;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                en_i;
    logic                cfg_we_i;
    logic [4:0]          cfg_ch_i;
    logic [1:0]          cfg_mode_i;
    logic [TAP_W-1:0]    cfg_tap_a_i;
    logic [TAP_W-1:0]    cfg_tap_b_i;
    logic                cfg_inv_i;
    logic [15:0]         cfg_burst_i;
    logic                cfg_commit_i;
    logic [CHANNELS-1:0] fin_o;
    logic [CHANNELS-1:0] busy_o;
    logic [CHANNELS-1:0] done_o;

    int n_checks = 0;
    int n_pass   = 0;

    fin_test_gen #(
        .CHANNELS(CHANNELS),
        .CNT_W   (32),
        .TAP_W   (TAP_W),
        .CH_W    (5),
        .BURST_W (16)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_tap_a_i (cfg_tap_a_i),
        .cfg_tap_b_i (cfg_tap_b_i),
        .cfg_inv_i   (cfg_inv_i),
        .cfg_burst_i (cfg_burst_i),
        .cfg_commit_i(cfg_commit_i),
        .fin_o       (fin_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] ch, input logic [1:0] mode,
                             input logic [TAP_W-1:0] a, input logic [TAP_W-1:0] b,
                             input logic inv, input logic [15:0] burst, input logic commit);
        cfg_we_i     = 1'b1;
        cfg_ch_i     = ch;
        cfg_mode_i   = mode;
        cfg_tap_a_i  = a;
        cfg_tap_b_i  = b;
        cfg_inv_i    = inv;
        cfg_burst_i  = burst;
        cfg_commit_i = commit;
        tick();
        cfg_we_i     = 1'b0;
        cfg_commit_i = 1'b0;
    endtask

    task automatic commit_only();
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
    endtask

    initial begin
        int lo_hi, up_hi, rises, hi_cnt, any_hi, any_busy;
        logic prev;
        logic fe, be, de;

        rst_i = 1'b0; en_i = 1'b0; cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_mode_i = '0;
        cfg_tap_a_i = '0; cfg_tap_b_i = '0; cfg_inv_i = 1'b0; cfg_burst_i = '0;
        cfg_commit_i = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_fin",  32'(fin_o),  32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        rst_i = 1'b1;
        en_i  = 1'b1;

        // Shadow write alone must not change outputs
        cfg_write(5'd0, M_TAP, 6'd0, 6'd0, 1'b0, 16'd0, 1'b0);
        any_hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fin_o != '0) any_hi++;
        end
        check("nocommit_fin", 32'(any_hi), 32'd0);

        // TAP tap 0: period 2, first high two cycles after commit
        commit_only();
        for (int n = 1; n <= 6; n++) begin
            tick();
            check("tap0_fin", 32'(fin_o[0]), 32'((n - 1) & 1));
        end
        check("tap0_busy", 32'(busy_o[0]), 32'd0);
        check("tap0_done", 32'(done_o[0]), 32'd0);

        // AND taps 3 & 8: 8-wide pulses, period 16, only in upper half of 512
        cfg_write(5'd1, M_AND, 6'd3, 6'd8, 1'b0, 16'd0, 1'b1);
        lo_hi = 0; up_hi = 0; rises = 0; prev = 1'b0;
        for (int n = 1; n <= 512; n++) begin
            tick();
            if (fin_o[1]) begin
                if (n - 1 < 256) lo_hi++; else up_hi++;
                if (!prev) rises++;
            end
            prev = fin_o[1];
            if (n == 265) check("and_first_hi", 32'(fin_o[1]), 32'd1);
            if (n == 264) check("and_before_hi", 32'(fin_o[1]), 32'd0);
        end
        check("and_low_half", 32'(lo_hi), 32'd0);
        check("and_up_half",  32'(up_hi), 32'd128);
        check("and_pulses",   32'(rises), 32'd16);

        // BURST: ch2 tap 2 x3, ch4 zero-count burst
        cfg_write(5'd4, M_BURST, 6'd0, 6'd0, 1'b0, 16'd0, 1'b0);
        cfg_write(5'd2, M_BURST, 6'd2, 6'd0, 1'b0, 16'd3, 1'b1);
        check("burst_busy_e",  32'(busy_o[2]), 32'd0);
        check("burst_done_e",  32'(done_o[2]), 32'd0);
        check("burst0_done_e", 32'(done_o[4]), 32'd0);
        for (int n = 1; n <= 40; n++) begin
            tick();
            fe = (n >= 5 && n <= 8) || (n >= 13 && n <= 16) || (n >= 21 && n <= 24);
            be = (n <= 24);
            de = (n >= 25);
            check($sformatf("burst_fin_%0d", n),  32'(fin_o[2]),  32'(fe));
            check($sformatf("burst_busy_%0d", n), 32'(busy_o[2]), 32'(be));
            check($sformatf("burst_done_%0d", n), 32'(done_o[2]), 32'(de));
            check("burst0_done", 32'(done_o[4]), 32'd1);
            check("burst0_busy", 32'(busy_o[4]), 32'd0);
            check("burst0_fin",  32'(fin_o[4]),  32'd0);
        end
        check("and_busy", 32'(busy_o[1]), 32'd0);
        check("and_done", 32'(done_o[1]), 32'd0);

        // Clamp + inversion: tap 40 -> ~cnt[31], stays 1 here
        cfg_write(5'd3, M_TAP, 6'd40, 6'd0, 1'b1, 16'd0, 1'b1);
        hi_cnt = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (fin_o[3]) hi_cnt++;
        end
        check("clamp_inv_hi", 32'(hi_cnt), 32'd300);

        // Write-through commit: ch0 TAP tap 1 -> period 4
        cfg_write(5'd0, M_TAP, 6'd1, 6'd0, 1'b0, 16'd0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            if (n == 9) begin
                // shadow-only write, must not change the pattern
                cfg_write(5'd0, M_TAP, 6'd2, 6'd0, 1'b0, 16'd0, 1'b0);
            end else begin
                tick();
            end
            check($sformatf("wt_fin_%0d", n), 32'(fin_o[0]), 32'(((n - 1) >> 1) & 1));
        end
        // Commit while frozen: fin holds, counter restarts
        en_i = 1'b0;
        commit_only();
        check("frz_fin_e", 32'(fin_o[0]), 32'd1);
        tick();
        check("frz_fin_1", 32'(fin_o[0]), 32'd1);
        tick();
        check("frz_fin_2", 32'(fin_o[0]), 32'd1);
        en_i = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            tick();
            check($sformatf("restart_fin_%0d", m), 32'(fin_o[0]), 32'(((m - 1) >> 2) & 1));
        end

        // Reset mid-burst (second pulse of 5)
        cfg_write(5'd2, M_BURST, 6'd2, 6'd0, 1'b0, 16'd5, 1'b1);
        for (int n = 1; n <= 14; n++) tick();
        check("mid_fin",  32'(fin_o[2]),  32'd1);
        check("mid_busy", 32'(busy_o[2]), 32'd1);
        rst_i = 1'b0;
        #1;
        check("arst_fin",  32'(fin_o),  32'h0);
        check("arst_busy", 32'(busy_o), 32'h0);
        check("arst_done", 32'(done_o), 32'h0);
        tick();
        rst_i = 1'b1;
        any_hi = 0; any_busy = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (fin_o != '0) any_hi++;
            if (busy_o != '0 || done_o != '0) any_busy++;
        end
        check("post_rst_fin",  32'(any_hi),   32'd0);
        check("post_rst_busy", 32'(any_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fin_test_gen.md
# fin_test_gen

Parametrised multi-channel test-frequency generator for freqMeter self-test and bring-up. A free-running divider counter feeds per-channel tap selectors that produce square waves, AND-combined patterns or counted bursts, driving the `Fin` inputs of the frequency-measurement core. Per-channel configuration is written into shadow registers and applied atomically to all channels with a phase-coherent restart.

## Interface
- `CHANNELS`, 24: number of output channels.
- `CNT_W`, 32: divider counter width.
- `TAP_W`, 5: tap index width; must satisfy 2^TAP_W ≥ CNT_W.
- `CH_W`, 5: channel select width; must satisfy 2^CH_W ≥ CHANNELS.
- `BURST_W`, 16: burst pulse count width.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  count enable; 0 freezes the counter and all channel state.
- `cfg_we_i`  in  1  writes the `cfg_*` fields into the shadow register of channel `cfg_ch_i`.
- `cfg_ch_i`  in  CH_W  channel select; a value ≥ CHANNELS makes the write a no-op.
- `cfg_mode_i`  in  2  mode: 00 OFF, 01 TAP, 10 AND, 11 BURST.
- `cfg_tap_a_i`, `cfg_tap_b_i`  in  TAP_W  counter bit indices.
- `cfg_inv_i`  in  1  output inversion.
- `cfg_burst_i`  in  BURST_W  pulse count for BURST mode.
- `cfg_commit_i`  in  1  copies all shadow registers to the active registers and restarts.
- `fin_o`  out  CHANNELS  generated signals, registered.
- `busy_o`  out  CHANNELS  BURST in progress.
- `done_o`  out  CHANNELS  BURST complete; sticky until the next commit.

## Operation
- **Counter.** `cnt` increments by 1 per clock while `en_i` = 1. It wraps from 2^CNT_W−1 to 0.
- **Tap clamp.** Any tap index ≥ CNT_W is treated as CNT_W−1.
- **Raw value per channel**, before inversion:
  - OFF: 0.
  - TAP: `cnt[a]`.
  - AND: `cnt[a] & cnt[b]`.
  - BURST: gated `cnt[a]`, as defined below.
- **Output.** `fin_o[k]` is `raw ^ inv`, registered.
- **BURST state per channel:** `remaining` (BURST_W bits), `admitted`, `prev_tap`.
  - `rise` = `cnt[a] & ~prev_tap`.
  - On a rise with `remaining` ≠ 0: decrement `remaining` and set `admitted`.
  - raw = `cnt[a] & (admitted | (rise & remaining≠0))`.
  - A falling tap clears `admitted`.
  - `done` sets on the fall that ends the last admitted pulse.
  - `busy` = BURST mode & ~`done`.
  - After `done`, raw stays 0 (output = `inv`).
- **Burst count 0.** `done` sets on the cycle after commit; no pulses are emitted.
- **Commit, applied in one cycle:**
  - active ← shadow for all channels;
  - `cnt` ← 0;
  - `prev_tap` ← 0 and `admitted` ← 0;
  - `remaining` ← active burst value;
  - `done` ← 0.
  - A commit is honoured regardless of `en_i`.
- **Simultaneous `cfg_we_i` and `cfg_commit_i`.** The write is included in the commit (write-through to active).
- **Writes without commit.** These affect shadow registers only; outputs are unchanged.
- **Other modes.** `busy_o` and `done_o` are 0 in OFF, TAP and AND.

## Timing
- **Reset.** All of the following are 0:
  - `cnt`;
  - shadow and active config (mode OFF, inv 0, taps 0, burst 0);
  - `fin_o`;
  - `busy_o` and `done_o`;
  - `remaining`, `admitted`, `prev_tap`.
- **Latency.** The counter value at cycle t is reflected on `fin_o` at t+1.
- **Commit sequence.** Commit sampled at edge E:
  - `cnt` = 0 after E;
  - `fin_o` reflects the new config with `cnt` = 0 after E+1;
  - `busy_o` rises after E+1;
  - `done_o` is cleared after E.
- **Freeze.** With `en_i` = 0, `fin_o`, `busy_o` and `done_o` hold their values.
- **Reset mid-burst.** Assertion clears state immediately (asynchronous). Deassertion is synchronised externally.

## Test plan
- **TAP, tap 0.** Ch0 TAP, tap_a = 0, commit, en = 1 → `fin_o[0]` toggles every clock, period 2. First high 2 cycles after commit.
- **AND, taps 3 and 8.** Ch1 AND, a = 3, b = 8 → pulses of 8 cycles at period 16, present only in the upper 256 of each 512-cycle window.
- **BURST, 3 pulses.** Ch2 BURST, tap 2, burst = 3 → exactly 3 high pulses of 4 cycles at period 8. `done_o[2]` rises after the third fall. `busy_o` is high throughout and low after. Output stays 0 thereafter.
- **Inversion and clamp.** Ch3 TAP, tap 40, inv = 1 (CNT_W = 32) → behaves as `~cnt[31]`: 1 for the first 2^31 cycles.
- **Write and commit in one cycle.** Ch0 write TAP tap 1 in the same cycle as commit → period-4 output. A later write without commit leaves `fin_o` unchanged. A commit with `en_i` = 0 still restarts the counter.
- **Reset mid-burst.** `rst_i` low during the second pulse of a burst of 5 → all outputs 0 at once. After release, ch2 is OFF until a new commit.
